// File: rtl/alu_pkg.sv
// Shared control encodings for the 6502 datapath: ALU opcodes and flag bit positions.
package control_signals;

    typedef enum logic [3:0] {
        ALU_ADD          = 4'd0,
        ALU_SUB          = 4'd1,
        ALU_AND          = 4'd2,
        ALU_OR           = 4'd3,
        ALU_XOR          = 4'd4,
        ALU_SHIFT_LEFT   = 4'd5,
        ALU_SHIFT_RIGHT  = 4'd6,
        ALU_ROTATE_LEFT  = 4'd7,
        ALU_ROTATE_RIGHT = 4'd8,
        ALU_PASS_A       = 4'd9
    } alu_op_t;

    // Bit positions of the registered flag vector inside the ALU.
    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

endpackage

// File: rtl/alu_bcd_adjust.sv
// Packed-BCD correction of a binary add/sub result; only built when ALU_DECIMAL_EN is defined.
`ifdef ALU_DECIMAL_EN
module alu_bcd_adjust (
    input  logic [7:0] sum_bin,
    input  logic       half_carry,
    input  logic       carry,
    input  logic       is_sub,
    output logic [7:0] adj_sum,
    output logic       adj_carry
);

    logic low_fix;
    logic high_fix;

    always_comb begin
        adj_sum   = sum_bin;
        adj_carry = carry;
        low_fix   = 1'b0;
        high_fix  = 1'b0;
        if (is_sub) begin
            // A missing nibble carry is a nibble borrow: pull that digit back by 6.
            low_fix  = ~half_carry;
            high_fix = ~carry;
            adj_sum  = sum_bin - {1'b0, high_fix, high_fix, 2'b00, low_fix, low_fix, 1'b0};
        end else begin
            // High check uses the uncorrected sum so a low-digit fix that rolls into the
            // high digit is still caught.
            low_fix   = half_carry || (sum_bin[3:0] > 4'd9);
            high_fix  = carry || (sum_bin > 8'h99);
            adj_sum   = sum_bin + {1'b0, high_fix, high_fix, 2'b00, low_fix, low_fix, 1'b0};
            adj_carry = high_fix;
        end
    end

endmodule
`endif

// File: rtl/alu.sv
// 8-bit 6502 ALU with registered result and N/Z/C/V flags.
// Define ALU_DECIMAL_EN to add the decimal_in port and packed-BCD ADD/SUB.
module alu
    import control_signals::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       carry_in,
    input  logic [7:0] input_a,
    input  logic [7:0] input_b,
    input  alu_op_t    operation,
`ifdef ALU_DECIMAL_EN
    input  logic       decimal_in,
`endif
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       zero_out,
    output logic       negative_out,
    output logic       overflow_out
);

    logic       is_sub;
    logic [7:0] b_eff;
    logic [8:0] sum_bin;
    logic       v_bin;
    logic [7:0] arith_res;
    logic       arith_c;
    logic [7:0] res_nxt;
    logic       c_nxt;
    logic       v_nxt;
    logic [7:0] res_p1;
    logic [3:0] flags_p1;

    // Subtraction reuses the adder: A + ~B + C, where C acts as not-borrow.
    assign is_sub  = (operation == ALU_SUB);
    assign b_eff   = is_sub ? ~input_b : input_b;
    assign sum_bin = {1'b0, input_a} + {1'b0, b_eff} + {8'd0, carry_in};
    assign v_bin   = (input_a[7] == b_eff[7]) && (sum_bin[7] != input_a[7]);

`ifdef ALU_DECIMAL_EN
    logic       half_carry;
    logic [7:0] bcd_res;
    logic       bcd_c;

    assign half_carry = input_a[4] ^ b_eff[4] ^ sum_bin[4];

    alu_bcd_adjust u_bcd_adjust (
        .sum_bin    (sum_bin[7:0]),
        .half_carry (half_carry),
        .carry      (sum_bin[8]),
        .is_sub     (is_sub),
        .adj_sum    (bcd_res),
        .adj_carry  (bcd_c)
    );

    assign arith_res = decimal_in ? bcd_res : sum_bin[7:0];
    assign arith_c   = decimal_in ? bcd_c   : sum_bin[8];
`else
    assign arith_res = sum_bin[7:0];
    assign arith_c   = sum_bin[8];
`endif

    always_comb begin
        res_nxt = input_a;
        c_nxt   = carry_in;
        v_nxt   = 1'b0;
        case (operation)
            ALU_ADD, ALU_SUB: begin
                res_nxt = arith_res;
                c_nxt   = arith_c;
                v_nxt   = v_bin;
            end
            ALU_AND:          res_nxt = input_a & input_b;
            ALU_OR:           res_nxt = input_a | input_b;
            ALU_XOR:          res_nxt = input_a ^ input_b;
            ALU_SHIFT_LEFT: begin
                res_nxt = {input_a[6:0], 1'b0};
                c_nxt   = input_a[7];
            end
            ALU_SHIFT_RIGHT: begin
                res_nxt = {1'b0, input_a[7:1]};
                c_nxt   = input_a[0];
            end
            ALU_ROTATE_LEFT: begin
                res_nxt = {input_a[6:0], carry_in};
                c_nxt   = input_a[7];
            end
            ALU_ROTATE_RIGHT: begin
                res_nxt = {carry_in, input_a[7:1]};
                c_nxt   = input_a[0];
            end
            default:          res_nxt = input_a;
        endcase
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p1   <= 8'd0;
            flags_p1 <= 4'd0;
        end else begin
            res_p1           <= res_nxt;
            flags_p1[FLAG_C] <= c_nxt;
            flags_p1[FLAG_Z] <= (res_nxt == 8'd0);
            flags_p1[FLAG_N] <= res_nxt[7];
            flags_p1[FLAG_V] <= v_nxt;
        end
    end

    assign alu_out      = res_p1;
    assign carry_out    = flags_p1[FLAG_C];
    assign zero_out     = flags_p1[FLAG_Z];
    assign negative_out = flags_p1[FLAG_N];
    assign overflow_out = flags_p1[FLAG_V];

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus random ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu;
    import control_signals::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       carry_in = 1'b0;
    logic [7:0] input_a = 8'd0;
    logic [7:0] input_b = 8'd0;
    alu_op_t    operation = ALU_PASS_A;
`ifdef ALU_DECIMAL_EN
    logic       decimal_in = 1'b0;
`endif
    logic [7:0] alu_out;
    logic       carry_out, zero_out, negative_out, overflow_out;
    logic [11:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    alu dut (
        .clk          (clk),
        .rst          (rst),
        .carry_in     (carry_in),
        .input_a      (input_a),
        .input_b      (input_b),
        .operation    (operation),
`ifdef ALU_DECIMAL_EN
        .decimal_in   (decimal_in),
`endif
        .alu_out      (alu_out),
        .carry_out    (carry_out),
        .zero_out     (zero_out),
        .negative_out (negative_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    // Observed vector: {result, C, Z, N, V}
    assign obs = {alu_out, carry_out, zero_out, negative_out, overflow_out};

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int dec(input int v);
        return (v / 16) * 10 + (v % 16);
    endfunction

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    // Reference model from the arithmetic meaning of each opcode.
    function automatic logic [11:0] model(input int op, input int a, input int b, input int c, input int d);
        int r, cf, vf, s, sa;
        r = a; cf = c; vf = 0;
        case (op)
            0: begin
                s  = a + b + c;
                r  = s % 256;
                cf = (s > 255) ? 1 : 0;
                sa = sx(a) + sx(b) + c;
                vf = (sa > 127 || sa < -128) ? 1 : 0;
                if (d != 0) begin
                    s  = dec(a) + dec(b) + c;
                    cf = (s > 99) ? 1 : 0;
                    r  = bcd(s % 100);
                end
            end
            1: begin
                s  = a - b - (1 - c);
                r  = (s + 256) % 256;
                cf = (s >= 0) ? 1 : 0;
                sa = sx(a) - sx(b) - (1 - c);
                vf = (sa > 127 || sa < -128) ? 1 : 0;
                if (d != 0) begin
                    s  = dec(a) - dec(b) - (1 - c);
                    cf = (s >= 0) ? 1 : 0;
                    r  = bcd((s + 100) % 100);
                end
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 256;           cf = a / 128; end
            6: begin r = a / 2;                   cf = a % 2;   end
            7: begin r = (a * 2) % 256 + c;       cf = a / 128; end
            8: begin r = a / 2 + c * 128;         cf = a % 2;   end
            default: r = a;
        endcase
        return {r[7:0], cf[0], (r == 0), (r >= 128), vf[0]};
    endfunction

    task automatic apply(input int op, input int a, input int b, input int c, input int d);
        operation = alu_op_t'(op[3:0]);
        input_a   = a[7:0];
        input_b   = b[7:0];
        carry_in  = c[0];
`ifdef ALU_DECIMAL_EN
        decimal_in = d[0];
`else
        if (d != 0) $display("note: decimal request ignored in binary build");
`endif
    endtask

    task automatic cycle(input int op, input int a, input int b, input int c, input int d);
        apply(op, a, b, c, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed res=%h CZNV=%b, required res=%h CZNV=%b",
                   tag, obs[11:4], obs[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    initial begin
        int op, a, b, c, d;

        // Reset held from time 0
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 12'h000);

        rst = 1'b0;
        cycle(0, 8'h12, 8'h34, 0, 0);
        check("pre_reset_add", {8'h46, 4'b0000});

        // Asynchronous reset mid-cycle, no clock edge in between
        #2 rst = 1'b1;
        #1;
        check("async_reset", 12'h000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 12'h000);

        rst = 1'b0;
        cycle(0, 5, 5, 1, 0);
        check("post_reset_add", {8'h0B, 4'b0000});

        cycle(1, 4, 5, 0, 0);
        check("sub_4_5", {8'hFE, 4'b0010});
        cycle(1, 3, 8, 0, 0);
        check("sub_3_8", {8'hFA, 4'b0010});
        cycle(1, 5, 5, 0, 0);
        check("sub_5_5_c0", {8'hFF, 4'b0010});
        cycle(1, 5, 5, 1, 0);
        check("sub_5_5_c1", {8'h00, 4'b1100});

        cycle(5, 8'hC3, 8'h01, 0, 0);
        check("shift_left", {8'h86, 4'b1010});
        cycle(8, 8'h01, 8'h00, 1, 0);
        check("rotate_right", {8'h80, 4'b1010});

        cycle(0, 8'h50, 8'h50, 0, 0);
        check("add_overflow", {8'hA0, 4'b0011});
        cycle(0, 8'hFF, 8'h01, 0, 0);
        check("add_wrap", {8'h00, 4'b1100});

        cycle(2, 8'hF0, 8'h0F, 1, 0);
        check("and_zero_c1", {8'h00, 4'b1100});
        cycle(2, 8'hF0, 8'h0F, 0, 0);
        check("and_zero_c0", {8'h00, 4'b0100});
        cycle(4, 8'hAA, 8'hFF, 0, 0);
        check("xor", {8'h55, 4'b0000});
        cycle(7, 8'h80, 8'h00, 1, 0);
        check("rotate_left", {8'h01, 4'b1000});
        cycle(15, 8'h9C, 8'h00, 1, 0);
        check("op15_pass_a", {8'h9C, 4'b1010});

`ifdef ALU_DECIMAL_EN
        cycle(0, 8'h19, 8'h28, 0, 1);
        check("bcd_add_19_28", {8'h47, 4'b0000});
        cycle(0, 8'h99, 8'h01, 0, 1);
        check("bcd_add_99_01", {8'h00, 4'b1100});
        cycle(1, 8'h10, 8'h01, 1, 1);
        check("bcd_sub_10_01", {8'h09, 4'b1000});
        cycle(4, 8'h0F, 8'h0F, 0, 1);
        check("bcd_xor_unaffected", {8'h00, 4'b0100});
`endif

        // Randomized ops against the reference model
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 15));
            c  = int'($urandom_range(0, 1));
`ifdef ALU_DECIMAL_EN
            d  = int'($urandom_range(0, 1));
`else
            d  = 0;
`endif
            if (d != 0) begin
                a = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
                b = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
            end else begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
            end
            cycle(op, a, b, c, d);
            check($sformatf("rand_op%0d_a%0h_b%0h_c%0d_d%0d", op, a, b, c, d), model(op, a, b, c, d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
